multi_channel_stream_arbiter: RTL
=================================

// Module: multi_channel_stream_arbiter
// PURPOSE
//  - N-channel valid/ready stream concentrator: each input channel is buffered in its own FIFO and merged
//    onto one output stream by a configurable arbiter, tagged with the source channel index.
//  - DUT for the agent/env testbench components: N input agents drive it, one output monitor/agent checks it.
//  - Successor to the single-channel pass-through: generalised in width, depth and channel count, plus an
//    arbitration mode and output backpressure.
// PARAMETERS
//  NUM_CHANNELS  4         number of input channels, >= 1
//  DATA_WIDTH    32        payload width in bits, >= 1
//  FIFO_DEPTH    4         entries per channel FIFO, power of 2, >= 2
//  ARB_MODE      ARB_RR    arb_mode_e: ARB_RR = round robin, ARB_FIXED = lowest index wins
//  (derived) CH_W = max(1, $clog2(NUM_CHANNELS)); LVL_W = $clog2(FIFO_DEPTH)+1
// PORTS
//  clk          in   1                        single clock, all logic on rising edge
//  rst_n        in   1                        asynchronous, active-low reset
//  in_valid     in   NUM_CHANNELS             per-channel valid
//  in_ready     out  NUM_CHANNELS             per-channel ready
//  in_data      in   NUM_CHANNELS*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
//  out_valid    out  1                        output word valid
//  out_ready    in   1                        downstream ready
//  out_data     out  DATA_WIDTH               output payload
//  out_channel  out  CH_W                     source channel of out_data
//  fifo_level   out  NUM_CHANNELS*LVL_W       per-channel occupancy, 0..FIFO_DEPTH
// BEHAVIOUR
//  - Reset (async assert, sync release): all FIFOs empty, out_valid=0, out_data=0, out_channel=0,
//    fifo_level=0, RR pointer = NUM_CHANNELS-1 (channel 0 served first). in_ready=0 while rst_n=0 and for
//    the first edge after release (registered enable); then in_ready[c] = !full[c].
//  - Reset mid-operation: all buffered and output words are discarded; nothing is emitted after release
//    until new input arrives.
//  - Input: a push happens on an edge where in_valid[c] && in_ready[c]. in_ready depends only on FIFO state,
//    never on in_valid or out_ready. Full FIFO: in_ready=0, with no bypass even when a pop occurs in the
//    same cycle.
//  - Output register: loaded at an edge when (!out_valid || out_ready) and any FIFO is non-empty; the
//    granted FIFO is popped on that same edge. While out_valid && !out_ready, out_data and out_channel hold
//    stable.
//  - Latency: a word pushed at edge k into an empty system shows out_valid=1 after edge k+1. No input-to-output
//    combinational path.
//  - Throughput: 1 word/cycle with out_ready held at 1.
//  - ARB_RR: search starts at (last_grant+1) mod N and wraps. last_grant updates only on a pop.
//  - ARB_FIXED: lowest-index non-empty channel wins; starvation is allowed.
//  - Per-FIFO push and pop in the same cycle: both occur and the level is unchanged. Pointers wrap mod FIFO_DEPTH.
//  - fifo_level is registered and reflects the post-edge occupancy.
//  - NUM_CHANNELS=1: the arbiter degenerates; out_channel is always 0.
// STRUCTURE
//  - Shared package stream_pkg: typedef enum {ARB_RR, ARB_FIXED} arb_mode_e; function clog2_min1().
//  - Sub-module stream_fifo (DATA_WIDTH, FIFO_DEPTH): sync FIFO with push/pop/full/empty/level, generated
//    once per channel.
//  - Top level: generate loop of FIFOs, arbiter (combinational grant + registered last_grant), output register.
// TESTING
//  1. Reset: rst_n=0 mid-stream with 3 words queued on ch1 -> out_valid=0, fifo_level=0, in_ready=0;
//     after release, in_ready=4'hF one edge later and no stale data is emitted.
//  2. Single word: ch2 pushes 32'hDEAD_BEEF at edge k, out_ready=1 -> after edge k+1: out_valid=1,
//     out_data=DEADBEEF, out_channel=2.
//  3. RR fairness: all 4 channels hold 3 words, out_ready=1 -> out_channel sequence 0,1,2,3,0,1,2,3,0,1,2,3.
//  4. Fixed mode (ARB_FIXED): ch0 and ch3 are continuously fed -> only ch0 is output; ch3 fills until
//     in_ready[3]=0 with fifo_level=4.
//  5. Backpressure: out_ready=0 for 10 cycles while ch1 pushes 5 words -> 1 word held stable in the output
//     register, 4 in the FIFO, in_ready[1]=0; releasing out_ready drains in order, 1 word/cycle.
//  6. Simultaneous push/pop on a full FIFO with in_valid=1 -> no push that cycle (in_ready=0); level 4->3;
//     the push is accepted the next cycle.

Source files
------------

// File: rtl/stream_pkg.sv
// stream_pkg: shared arbitration mode type and width helper for the stream arbiter
package stream_pkg;

    typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_e;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: single-clock FIFO with registered occupancy, one instance per input channel
module stream_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int LVL_W     = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic [LVL_W-1:0]      level
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = level == LVL_W'(FIFO_DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array needs no reset; only pointers and level define what is valid
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wdata;

    // Pointers wrap naturally since the depth is a power of two
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            level  <= level + LVL_W'(do_push) - LVL_W'(do_pop);
        end

endmodule

// File: rtl/multi_channel_stream_arbiter.sv
// multi_channel_stream_arbiter: per-channel FIFOs merged onto one tagged output stream
module multi_channel_stream_arbiter
    import stream_pkg::*;
#(
    parameter int        NUM_CHANNELS = 4,
    parameter int        DATA_WIDTH   = 32,
    parameter int        FIFO_DEPTH   = 4,
    parameter arb_mode_e ARB_MODE     = ARB_RR,
    localparam int       CH_W         = clog2_min1(NUM_CHANNELS),
    localparam int       LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CHANNELS-1:0]          in_valid,
    output logic [NUM_CHANNELS-1:0]          in_ready,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CH_W-1:0]                  out_channel,
    output logic [NUM_CHANNELS*LVL_W-1:0]    fifo_level
);

    logic                  in_en;
    logic [NUM_CHANNELS-1:0] fifo_full;
    logic [NUM_CHANNELS-1:0] fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata [NUM_CHANNELS];
    logic [CH_W-1:0]       last_grant;
    logic [CH_W-1:0]       grant;
    logic [CH_W-1:0]       cand;
    logic                  found;
    logic                  load;

    assign load = (!out_valid || out_ready) && found;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        assign in_ready[c] = in_en && !fifo_full[c];
        stream_fifo #(
            .DATA_WIDTH(DATA_WIDTH),
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk  (clk),
            .rst_n(rst_n),
            .push (in_valid[c] && in_ready[c]),
            .pop  (load && grant == CH_W'(c)),
            .wdata(in_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .rdata(fifo_rdata[c]),
            .full (fifo_full[c]),
            .empty(fifo_empty[c]),
            .level(fifo_level[c*LVL_W +: LVL_W])
        );
    end

    // Input enable comes up one edge after reset release so nothing is accepted on the release edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) in_en <= 1'b0;
        else        in_en <= 1'b1;

    // Grant search: fixed mode scans from channel 0, round robin scans from the channel after the last grant
    always_comb begin
        grant = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            cand = CH_W'((ARB_MODE == ARB_FIXED) ? i : (int'(last_grant) + 1 + i) % NUM_CHANNELS);
            if (!found && !fifo_empty[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    // Round-robin pointer advances only when a word is actually popped
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)    last_grant <= CH_W'(NUM_CHANNELS - 1);
        else if (load) last_grant <= grant;

    // Output register: reloads whenever empty or being consumed, otherwise holds the pending word
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
        end else if (load) begin
            out_valid   <= 1'b1;
            out_data    <= fifo_rdata[grant];
            out_channel <= grant;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end

endmodule
